// File: rtl/brq_tb_pkg.sv
// Shared types and default signatures for the Buraq test-harness monitor.
package brq_tb_pkg;

   typedef enum logic [1:0] {ST_RESET, ST_RUN, ST_DONE} brq_mon_state_e;

   localparam logic [31:0] BRQ_PASS_SIG = 32'h600D_C0DE;
   localparam logic [31:0] BRQ_FAIL_SIG = 32'hBAD0_0BAD;

endpackage

// File: rtl/brq_sig_detect.sv
// Per-core signature detector: latches the first PASS or FAIL signature seen
// while enabled and ignores everything afterwards until cleared.
module brq_sig_detect
   import brq_tb_pkg::*;
#(
   parameter int                DATA_W   = 32,
   parameter logic [DATA_W-1:0] PASS_SIG = DATA_W'(BRQ_PASS_SIG),
   parameter logic [DATA_W-1:0] FAIL_SIG = DATA_W'(BRQ_FAIL_SIG)
) (
   input  logic              clk,
   input  logic              clr,
   input  logic              en,
   input  logic [DATA_W-1:0] value,
   output logic              done,
   output logic              fail
);

   // Sticky done/fail flags; the first signature wins.
   always_ff @(posedge clk) begin
      if (clr) begin
         done <= 1'b0;
         fail <= 1'b0;
      end else if (en && !done) begin
         if (value == PASS_SIG) begin
            done <= 1'b1;
         end else if (value == FAIL_SIG) begin
            done <= 1'b1;
            fail <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/brq_test_monitor.sv
// Test-harness controller for N_CH Buraq cores: stretches reset into a per-run
// core reset, counts run cycles, collects pass/fail signatures, reports a verdict.
module brq_test_monitor
   import brq_tb_pkg::*;
#(
   parameter int                DATA_W     = 32,
   parameter int                N_CH       = 2,
   parameter int                RST_CYCLES = 4,
   parameter int                TIMEOUT    = 1000,
   parameter int                CNT_W      = 32,
   parameter logic [DATA_W-1:0] PASS_SIG   = DATA_W'(BRQ_PASS_SIG),
   parameter logic [DATA_W-1:0] FAIL_SIG   = DATA_W'(BRQ_FAIL_SIG)
) (
   input  logic                   brq_clk,
   input  logic                   brq_rst,
   input  logic [N_CH*DATA_W-1:0] reg_out_i,
   input  logic                   restart_i,
   output logic                   core_rst_o,
   output logic [CNT_W-1:0]       cycle_cnt_o,
   output logic [N_CH-1:0]        ch_done_o,
   output logic [N_CH-1:0]        fail_mask_o,
   output logic                   done_o,
   output logic                   pass_o,
   output logic                   timeout_o
);

   localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

   if (PASS_SIG == FAIL_SIG) begin : g_bad_sig
      $error("brq_test_monitor: PASS_SIG and FAIL_SIG must differ");
   end
   if (TIMEOUT < 1) begin : g_bad_timeout
      $error("brq_test_monitor: TIMEOUT must be >= 1");
   end
   if (RST_CYCLES < 1) begin : g_bad_rst
      $error("brq_test_monitor: RST_CYCLES must be >= 1");
   end

   brq_mon_state_e    state, state_nxt;
   logic [RC_W-1:0]   rst_cnt, rst_cnt_nxt;
   logic              core_rst_nxt;
   logic [CNT_W-1:0]  cnt_nxt;
   logic              done_nxt, pass_nxt, timeout_nxt;
   logic              en, clr, all_done_nxt;
   logic [N_CH-1:0]   pass_hit, fail_hit;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
      return (&x) ? x : x + 1'b1;
   endfunction

   // Matching is only live in RUN, where the cores are out of reset.
   assign en  = (state == ST_RUN);
   assign clr = brq_rst || ((state == ST_DONE) && restart_i);

   for (genvar k = 0; k < N_CH; k++) begin : g_ch
      logic [DATA_W-1:0] value;
      assign value       = reg_out_i[k*DATA_W +: DATA_W];
      assign pass_hit[k] = en && !ch_done_o[k] && (value == PASS_SIG);
      assign fail_hit[k] = en && !ch_done_o[k] && (value == FAIL_SIG);

      brq_sig_detect #(
         .DATA_W   (DATA_W),
         .PASS_SIG (PASS_SIG),
         .FAIL_SIG (FAIL_SIG)
      ) u_det (
         .clk   (brq_clk),
         .clr   (clr),
         .en    (en),
         .value (value),
         .done  (ch_done_o[k]),
         .fail  (fail_mask_o[k])
      );
   end

   // Completion includes channels that report on this very edge.
   assign all_done_nxt = &(ch_done_o | pass_hit | fail_hit);

   // Next-state and next-output logic for the RESET/RUN/DONE sequencer.
   always_comb begin
      state_nxt    = state;
      rst_cnt_nxt  = rst_cnt;
      core_rst_nxt = core_rst_o;
      cnt_nxt      = cycle_cnt_o;
      done_nxt     = done_o;
      pass_nxt     = pass_o;
      timeout_nxt  = timeout_o;
      unique case (state)
         ST_RESET: begin
            if (rst_cnt == RC_W'(RST_CYCLES - 1)) begin
               state_nxt    = ST_RUN;
               core_rst_nxt = 1'b0;
               rst_cnt_nxt  = '0;
            end else begin
               rst_cnt_nxt = rst_cnt + 1'b1;
            end
         end
         ST_RUN: begin
            if (all_done_nxt) begin
               // Completion beats timeout when both land on the same edge.
               state_nxt   = ST_DONE;
               done_nxt    = 1'b1;
               timeout_nxt = 1'b0;
               pass_nxt    = ~|(fail_mask_o | fail_hit);
               cnt_nxt     = sat_inc(cycle_cnt_o);
            end else if (cycle_cnt_o == CNT_W'(TIMEOUT - 1)) begin
               // Timeout freezes the count at TIMEOUT-1.
               state_nxt   = ST_DONE;
               done_nxt    = 1'b1;
               timeout_nxt = 1'b1;
               pass_nxt    = 1'b0;
            end else begin
               cnt_nxt = sat_inc(cycle_cnt_o);
            end
         end
         ST_DONE: begin
            if (restart_i) begin
               state_nxt    = ST_RESET;
               rst_cnt_nxt  = '0;
               core_rst_nxt = 1'b1;
               cnt_nxt      = '0;
               done_nxt     = 1'b0;
               pass_nxt     = 1'b0;
               timeout_nxt  = 1'b0;
            end
         end
         default: begin
            state_nxt    = ST_RESET;
            rst_cnt_nxt  = '0;
            core_rst_nxt = 1'b1;
         end
      endcase
   end

   // State and output registers; brq_rst overrides everything.
   always_ff @(posedge brq_clk) begin
      if (brq_rst) begin
         state       <= ST_RESET;
         rst_cnt     <= '0;
         core_rst_o  <= 1'b1;
         cycle_cnt_o <= '0;
         done_o      <= 1'b0;
         pass_o      <= 1'b0;
         timeout_o   <= 1'b0;
      end else begin
         state       <= state_nxt;
         rst_cnt     <= rst_cnt_nxt;
         core_rst_o  <= core_rst_nxt;
         cycle_cnt_o <= cnt_nxt;
         done_o      <= done_nxt;
         pass_o      <= pass_nxt;
         timeout_o   <= timeout_nxt;
      end
   end

endmodule

// File: tb/tb_brq_test_monitor.sv
// Self-checking bench for brq_test_monitor with a run-level reference model.
module tb_brq_test_monitor;

   localparam int DATA_W     = 32;
   localparam int N_CH       = 2;
   localparam int RST_CYCLES = 4;
   localparam int TIMEOUT    = 1000;
   localparam int CNT_W      = 32;
   localparam logic [31:0] PSIG = 32'h600DC0DE;
   localparam logic [31:0] FSIG = 32'hBAD00BAD;

   logic                   clk = 1'b0;
   logic                   brq_rst;
   logic                   restart;
   logic [N_CH*DATA_W-1:0] reg_out;
   logic                   core_rst;
   logic [CNT_W-1:0]       cycle_cnt;
   logic [N_CH-1:0]        ch_done;
   logic [N_CH-1:0]        fail_mask;
   logic                   done;
   logic                   pass;
   logic                   timeout;

   always #5 clk = ~clk;

   brq_test_monitor #(
      .DATA_W     (DATA_W),
      .N_CH       (N_CH),
      .RST_CYCLES (RST_CYCLES),
      .TIMEOUT    (TIMEOUT),
      .CNT_W      (CNT_W),
      .PASS_SIG   (PSIG),
      .FAIL_SIG   (FSIG)
   ) dut (
      .brq_clk     (clk),
      .brq_rst     (brq_rst),
      .reg_out_i   (reg_out),
      .restart_i   (restart),
      .core_rst_o  (core_rst),
      .cycle_cnt_o (cycle_cnt),
      .ch_done_o   (ch_done),
      .fail_mask_o (fail_mask),
      .done_o      (done),
      .pass_o      (pass),
      .timeout_o   (timeout)
   );

   int checks   = 0;
   int failures = 0;

   // Stimulus per channel per run cycle, and the verdict derived from it.
   logic [31:0]      vals [N_CH][TIMEOUT];
   int               first_c [N_CH];
   bit               first_fail [N_CH];
   int               exp_end;
   bit               exp_to;
   bit               exp_pass;
   logic [CNT_W-1:0] exp_cnt;
   logic [N_CH-1:0]  exp_dmask;
   logic [N_CH-1:0]  exp_fmask;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] noise();
      logic [31:0] v;
      v = $urandom;
      if (v == PSIG || v == FSIG) v = 32'h0;
      return v;
   endfunction

   task automatic fill_noise();
      for (int k = 0; k < N_CH; k++)
         for (int c = 0; c < TIMEOUT; c++)
            vals[k][c] = noise();
   endtask

   // Verdict from first-signature positions: the run ends when the slowest
   // channel reports, or at cycle TIMEOUT-1 if some channel never does.
   task automatic build_model();
      bit all_seen;
      int last;
      all_seen = 1'b1;
      last     = 0;
      for (int k = 0; k < N_CH; k++) begin
         first_c[k]    = TIMEOUT;
         first_fail[k] = 1'b0;
         for (int c = 0; c < TIMEOUT; c++) begin
            if (first_c[k] == TIMEOUT && (vals[k][c] == PSIG || vals[k][c] == FSIG)) begin
               first_c[k]    = c;
               first_fail[k] = (vals[k][c] == FSIG);
            end
         end
         if (first_c[k] == TIMEOUT) all_seen = 1'b0;
         else if (first_c[k] > last) last = first_c[k];
      end
      if (all_seen) begin
         exp_end = last;
         exp_to  = 1'b0;
         exp_cnt = CNT_W'(last + 1);
      end else begin
         exp_end = TIMEOUT - 1;
         exp_to  = 1'b1;
         exp_cnt = CNT_W'(TIMEOUT - 1);
      end
      for (int k = 0; k < N_CH; k++) begin
         exp_dmask[k] = (first_c[k] <= exp_end);
         exp_fmask[k] = exp_dmask[k] && first_fail[k];
      end
      exp_pass = !exp_to && (exp_fmask == '0);
   endtask

   function automatic logic [N_CH-1:0] done_after(input int c);
      logic [N_CH-1:0] m;
      for (int k = 0; k < N_CH; k++) m[k] = (first_c[k] <= c);
      return m;
   endfunction

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_core_rst"}, core_rst, 1'b1);
      chk({tag, "_cnt"}, cycle_cnt, '0);
      chk({tag, "_ch_done"}, ch_done, '0);
      chk({tag, "_fmask"}, fail_mask, '0);
      chk({tag, "_done"}, done, 1'b0);
      chk({tag, "_pass"}, pass, 1'b0);
      chk({tag, "_timeout"}, timeout, 1'b0);
   endtask

   // Core reset must stay high for exactly RST_CYCLES cycles; signatures
   // presented meanwhile must not register.
   task automatic wait_release(input string tag);
      reg_out = {N_CH{PSIG}};
      for (int i = 0; i < RST_CYCLES; i++) begin
         chk({tag, "_rst_hold"}, core_rst, 1'b1);
         chk({tag, "_rst_cnt0"}, cycle_cnt, '0);
         step();
      end
      chk({tag, "_rst_release"}, core_rst, 1'b0);
      chk({tag, "_no_match_in_rst"}, ch_done, '0);
      chk({tag, "_cnt_start"}, cycle_cnt, '0);
      chk({tag, "_not_done"}, done, 1'b0);
   endtask

   // Plays the stored run; stop_at >= 0 pulses brq_rst on that run cycle.
   task automatic run(input string tag, input int stop_at);
      for (int c = 0; c <= exp_end; c++) begin
         for (int k = 0; k < N_CH; k++) reg_out[k*DATA_W +: DATA_W] = vals[k][c];
         restart = ($urandom_range(0, 3) == 0);
         if (c == stop_at) begin
            brq_rst = 1'b1;
            step();
            brq_rst = 1'b0;
            restart = 1'b0;
            return;
         end
         step();
         if (c < exp_end) begin
            chk({tag, "_run_cnt"}, cycle_cnt, CNT_W'(c + 1));
            chk({tag, "_run_ch_done"}, ch_done, done_after(c));
            chk({tag, "_run_done"}, done, 1'b0);
         end
      end
      restart = 1'b0;
      chk({tag, "_done"}, done, 1'b1);
      chk({tag, "_pass"}, pass, exp_pass);
      chk({tag, "_timeout"}, timeout, exp_to);
      chk({tag, "_cnt"}, cycle_cnt, exp_cnt);
      chk({tag, "_ch_done"}, ch_done, exp_dmask);
      chk({tag, "_fmask"}, fail_mask, exp_fmask);
      reg_out = {N_CH{FSIG}};
      for (int i = 0; i < 3; i++) step();
      chk({tag, "_frz_cnt"}, cycle_cnt, exp_cnt);
      chk({tag, "_frz_ch_done"}, ch_done, exp_dmask);
      chk({tag, "_frz_fmask"}, fail_mask, exp_fmask);
      chk({tag, "_frz_done"}, done, 1'b1);
      chk({tag, "_frz_pass"}, pass, exp_pass);
   endtask

   task automatic do_restart(input string tag);
      restart = 1'b1;
      step();
      restart = 1'b0;
      chk_reset_vals({tag, "_restart"});
      wait_release(tag);
   endtask

   initial begin
      brq_rst = 1'b1;
      restart = 1'b0;
      reg_out = '0;
      for (int i = 0; i < 3; i++) step();
      chk_reset_vals("por");
      brq_rst = 1'b0;
      wait_release("por");

      // Both channels pass, ch0 at 10 and ch1 at 20.
      fill_noise();
      vals[0][10] = PSIG;
      vals[1][20] = PSIG;
      build_model();
      run("two_pass", -1);
      chk("two_pass_cnt21", cycle_cnt, 21);
      chk("two_pass_verdict", pass, 1'b1);
      do_restart("r1");

      // ch1 fails then passes: first signature wins.
      fill_noise();
      vals[1][5] = FSIG;
      vals[1][6] = PSIG;
      vals[0][8] = PSIG;
      build_model();
      run("first_wins", -1);
      chk("first_wins_mask", fail_mask, 2'b10);
      chk("first_wins_verdict", pass, 1'b0);
      do_restart("r2");

      // No signatures at all: timeout.
      fill_noise();
      build_model();
      run("timeout", -1);
      chk("timeout_cnt999", cycle_cnt, 999);
      chk("timeout_flag", timeout, 1'b1);
      do_restart("r3");

      // Last channel completes on the timeout edge.
      fill_noise();
      vals[0][100] = PSIG;
      vals[1][TIMEOUT-1] = PSIG;
      build_model();
      run("edge_pass", -1);
      chk("edge_pass_timeout", timeout, 1'b0);
      chk("edge_pass_verdict", pass, 1'b1);
      do_restart("r4");

      // brq_rst pulsed mid-run after ch0 has passed.
      fill_noise();
      vals[0][10] = PSIG;
      build_model();
      run("mid_rst", 50);
      chk_reset_vals("mid_rst_after");
      wait_release("mid_rst");

      // Randomized runs with random signature placement and kinds.
      for (int r = 0; r < 5; r++) begin
         fill_noise();
         for (int k = 0; k < N_CH; k++) begin
            int pos;
            pos = $urandom_range(0, 300);
            if ($urandom_range(0, 9) != 0) begin
               vals[k][pos] = ($urandom_range(0, 2) == 0) ? FSIG : PSIG;
               if ($urandom_range(0, 1) == 1)
                  vals[k][pos + 1] = ($urandom_range(0, 1) == 1) ? FSIG : PSIG;
            end
         end
         build_model();
         run("rand", -1);
         do_restart("rr");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
